// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock monitor: FSM state encoding,
// error flag bit positions and the half-period range check.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_STUCK = 2;
  localparam int ERR_W     = 3;

  // Flags a measured half-period that falls outside [lo, hi].
  function automatic logic [ERR_W-1:0] range_flags(input logic [31:0] val,
                                                   input logic [31:0] lo,
                                                   input logic [31:0] hi);
    logic [ERR_W-1:0] flags;
    flags            = '0;
    flags[ERR_SHORT] = (val < lo);
    flags[ERR_LONG]  = (val > hi);
    return flags;
  endfunction

endpackage

// File: rtl/clk_monitor_if.sv
// Monitored-clock input, error clear and measurement results of clk_monitor.
// master: the side that drives mon_clk/clr and consumes the results.
// slave:  the monitor itself.
interface clk_monitor_if #(
  parameter int unsigned CNT_W = 16
);

  logic             mon_clk;
  logic             clr;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic [2:0]       err_pulse;
  logic [2:0]       err_status;
  logic             locked;

  modport master (
    output mon_clk,
    output clr,
    input  high_time,
    input  low_time,
    input  period,
    input  meas_valid,
    input  err_pulse,
    input  err_status,
    input  locked
  );

  modport slave (
    input  mon_clk,
    input  clr,
    output high_time,
    output low_time,
    output period,
    output meas_valid,
    output err_pulse,
    output err_status,
    output locked
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by an edge register. rise/fall are
// single-cycle pulses derived from the synchronized level, so both edges
// see identical latency.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  // Synchronizer chain plus one delayed copy for edge comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~edge_q;
  assign fall  = ~sync2_q & edge_q;

endmodule

// File: rtl/clk_monitor.sv
// Measures high/low time and period of an asynchronous clock in clk cycles,
// range-checks each half, detects a stuck clock and reports lock.
//
// state | meaning
// SEEK  | waiting for a rising edge to start measuring; cnt runs for timeout
// HIGH  | monitored clock is high, counting high time
// LOW   | monitored clock is low, counting low time; rise closes the period
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned HIGH_MIN = 2,
  parameter int unsigned HIGH_MAX = 64,
  parameter int unsigned LOW_MIN  = 2,
  parameter int unsigned LOW_MAX  = 64,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned LOCK_N   = 4
) (
  input logic         clk,
  input logic         rst,
  clk_monitor_if.slave mon_if
);

  localparam int unsigned LOCK_W = $clog2(LOCK_N + 1);
  // cnt is reloaded instead of stepping onto TIMEOUT, so it never wraps.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_N);

  logic mon_level;
  logic mon_rise;
  logic mon_fall;
  logic unused_level;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .din_i (mon_if.mon_clk),
    .level (mon_level),
    .rise  (mon_rise),
    .fall  (mon_fall)
  );

  assign unused_level = mon_level;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    high_q, high_d;
  logic [CNT_W-1:0]    low_q, low_d;
  logic [CNT_W:0]      period_q, period_d;
  logic                meas_q, meas_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ERR_W-1:0]    stat_q, stat_d;
  logic                high_bad_q, high_bad_d;
  logic [LOCK_W-1:0]   good_q, good_d;
  logic                locked_q, locked_d;
  logic [ERR_W-1:0]    half_flags;
  logic                edge_seen;
  logic                period_good;

  // Register all state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEEK;
      cnt_q      <= '0;
      high_q     <= '0;
      low_q      <= '0;
      period_q   <= '0;
      meas_q     <= 1'b0;
      err_q      <= '0;
      stat_q     <= '0;
      high_bad_q <= 1'b0;
      good_q     <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      low_q      <= low_d;
      period_q   <= period_d;
      meas_q     <= meas_d;
      err_q      <= err_d;
      stat_q     <= stat_d;
      high_bad_q <= high_bad_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state: edge handling per state, timeout override, lock and status.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    high_d      = high_q;
    low_d       = low_q;
    period_d    = period_q;
    meas_d      = 1'b0;
    err_d       = '0;
    high_bad_d  = high_bad_q;
    good_d      = good_q;
    half_flags  = '0;
    edge_seen   = 1'b0;
    period_good = 1'b0;

    case (state_q)
      SEEK: begin
        if (mon_rise) begin
          edge_seen  = 1'b1;
          high_bad_d = 1'b0;
          cnt_d      = CNT_ONE;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (mon_fall) begin
          edge_seen  = 1'b1;
          half_flags = range_flags(32'(cnt_q), 32'(HIGH_MIN), 32'(HIGH_MAX));
          high_d     = cnt_q;
          err_d      = half_flags;
          high_bad_d = |half_flags;
          cnt_d      = CNT_ONE;
          state_d    = LOW;
        end
      end
      LOW: begin
        if (mon_rise) begin
          edge_seen   = 1'b1;
          half_flags  = range_flags(32'(cnt_q), 32'(LOW_MIN), 32'(LOW_MAX));
          low_d       = cnt_q;
          period_d    = {1'b0, high_q} + {1'b0, cnt_q};
          meas_d      = 1'b1;
          err_d       = half_flags;
          period_good = ~high_bad_q & ~(|half_flags);
          high_bad_d  = 1'b0;
          cnt_d       = CNT_ONE;
          state_d     = HIGH;
        end
      end
      default: begin
        cnt_d   = CNT_ONE;
        state_d = SEEK;
      end
    endcase

    // No edge for TIMEOUT-1 cycles since the last reload: the clock is stuck.
    if (!edge_seen && (cnt_q == CNT_LAST)) begin
      err_d[ERR_STUCK] = 1'b1;
      cnt_d            = CNT_ONE;
      state_d          = SEEK;
    end

    if (|err_d) begin
      good_d = '0;
    end else if (meas_d && period_good && (good_q != LOCK_MAX)) begin
      good_d = good_q + LOCK_W'(1);
    end

    locked_d = (good_q == LOCK_MAX);

    // A new error outranks a simultaneous clear.
    stat_d = (mon_if.clr ? '0 : stat_q) | err_q;
  end

  assign mon_if.high_time  = high_q;
  assign mon_if.low_time   = low_q;
  assign mon_if.period     = period_q;
  assign mon_if.meas_valid = meas_q;
  assign mon_if.err_pulse  = err_q;
  assign mon_if.err_status = stat_q;
  assign mon_if.locked     = locked_q;

endmodule
